// File: rtl/irq_controller_pkg.sv
// Shared definitions for the interrupt controller: sequencing states and
// default vector layout.
package core_pkg;

   localparam int unsigned NUM_IRQ    = 4;
   localparam int unsigned VEC_BASE   = 32'h0000_0010;
   localparam int unsigned VEC_STRIDE = 4;

   typedef enum logic {
      IDLE,
      REQ
   } irq_state_e;

endpackage

// File: rtl/irq_controller_prio_enc.sv
// Lowest-index priority encoder: reports the first set bit of req_i and
// whether any bit is set at all.
module irq_prio_enc #(
   parameter int unsigned N     = 4,
   parameter int unsigned IDX_W = 2
) (
   input  logic [N-1:0]     req,
   output logic [IDX_W-1:0] idx,
   output logic             valid
);

   always_comb begin
      idx   = '0;
      valid = 1'b0;
      for (int unsigned i = 0; i < N; i++) begin
         if (req[i] && !valid) begin
            idx   = IDX_W'(i);
            valid = 1'b1;
         end
      end
   end

endmodule

// File: rtl/irq_controller.sv
// Interrupt controller: edge-latches requests, masks and prioritises them
// against the nesting state, and hands one vector at a time to the sequencer.
module irq_controller #(
   parameter int unsigned NUM_IRQ    = core_pkg::NUM_IRQ,
   parameter int unsigned PMA_SIZE   = 16,
   parameter int unsigned VEC_BASE   = core_pkg::VEC_BASE,
   parameter int unsigned VEC_STRIDE = core_pkg::VEC_STRIDE
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_IRQ-1:0]  irq_in,
   input  logic                ps_idle,
   input  logic                ps_irq_ack,
   input  logic                ps_rti,
   input  logic                imask_wr_en,
   input  logic [NUM_IRQ:0]    imask_wr_data,
   output logic [NUM_IRQ-1:0]  imask,
   output logic                gie,
   output logic [NUM_IRQ-1:0]  irptl,
   output logic [NUM_IRQ-1:0]  in_service,
   output logic                irq_req,
   output logic [PMA_SIZE-1:0] irq_vec,
   output logic                irq_wake
);

   import core_pkg::*;

   localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

   irq_state_e          state_q, state_d;
   logic [NUM_IRQ-1:0]  imask_q, imask_d;
   logic                gie_q, gie_d;
   logic [NUM_IRQ-1:0]  irptl_q, irptl_d;
   logic [NUM_IRQ-1:0]  insvc_q, insvc_d;
   logic [NUM_IRQ-1:0]  prev_q;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [PMA_SIZE-1:0] vec_q, vec_d;
   logic                wake_q, wake_d;

   logic [NUM_IRQ-1:0]  event_w;
   logic [NUM_IRQ-1:0]  ack_bit;
   logic [NUM_IRQ-1:0]  rti_bit;
   logic [IDX_W-1:0]    cand_idx, svc_idx;
   logic                cand_valid, svc_valid;
   logic                qualify;

   irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_cand_enc (
      .req   (irptl_q & imask_q),
      .idx   (cand_idx),
      .valid (cand_valid)
   );

   // Highest-priority interrupt in service: preemption threshold and RTI target.
   irq_prio_enc #(.N(NUM_IRQ), .IDX_W(IDX_W)) u_svc_enc (
      .req   (insvc_q),
      .idx   (svc_idx),
      .valid (svc_valid)
   );

   assign event_w = irq_in & ~prev_q;
   assign qualify = cand_valid && gie_q && (!svc_valid || (cand_idx < svc_idx));

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      vec_d   = vec_q;
      wake_d  = 1'b0;
      ack_bit = '0;
      rti_bit = '0;
      if (ps_rti && svc_valid) begin
         rti_bit[svc_idx] = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (qualify) begin
               state_d = REQ;
               idx_d   = cand_idx;
               vec_d   = PMA_SIZE'(VEC_BASE + VEC_STRIDE * 32'(cand_idx));
               wake_d  = ps_idle;
            end
         end
         REQ: begin
            if (ps_irq_ack) begin
               state_d        = IDLE;
               ack_bit[idx_q] = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      // A fresh edge re-latches even the bit being acknowledged this cycle.
      irptl_d = (irptl_q & ~ack_bit) | event_w;
      insvc_d = (insvc_q & ~rti_bit) | ack_bit;
      imask_d = imask_wr_en ? imask_wr_data[NUM_IRQ-1:0] : imask_q;
      gie_d   = imask_wr_en ? imask_wr_data[NUM_IRQ] : gie_q;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= IDLE;
         imask_q <= '0;
         gie_q   <= 1'b0;
         irptl_q <= '0;
         insvc_q <= '0;
         prev_q  <= '0;
         idx_q   <= '0;
         vec_q   <= '0;
         wake_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         imask_q <= imask_d;
         gie_q   <= gie_d;
         irptl_q <= irptl_d;
         insvc_q <= insvc_d;
         prev_q  <= irq_in;
         idx_q   <= idx_d;
         vec_q   <= vec_d;
         wake_q  <= wake_d;
      end
   end

   assign imask      = imask_q;
   assign gie        = gie_q;
   assign irptl      = irptl_q;
   assign in_service = insvc_q;
   assign irq_req    = (state_q == REQ);
   assign irq_vec    = vec_q;
   assign irq_wake   = wake_q;

endmodule

// File: tb/tb_irq_controller.sv
// Bench for irq_controller: directed scenarios plus randomized traffic, all
// checked every cycle against a behavioural model of the controller.
module tb_irq_controller;

   localparam int NUM = 4;
   localparam int VB  = 16;
   localparam int VS  = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  irq_in = '0;
   logic        ps_idle = 1'b0;
   logic        ps_irq_ack = 1'b0;
   logic        ps_rti = 1'b0;
   logic        imask_wr_en = 1'b0;
   logic [4:0]  imask_wr_data = '0;
   logic [3:0]  imask, irptl, in_service;
   logic        gie, irq_req, irq_wake;
   logic [15:0] irq_vec;

   int n_total = 0;
   int n_pass  = 0;

   bit m_pend [NUM];
   bit m_mask [NUM];
   bit m_svc  [NUM];
   bit m_prev [NUM];
   bit m_gie, m_busy, m_wake;
   int m_idx, m_vec;

   int rises, wakes;
   bit last_req;

   always #5 clk = ~clk;

   irq_controller dut (
      .clk           (clk),
      .reset         (reset),
      .irq_in        (irq_in),
      .ps_idle       (ps_idle),
      .ps_irq_ack    (ps_irq_ack),
      .ps_rti        (ps_rti),
      .imask_wr_en   (imask_wr_en),
      .imask_wr_data (imask_wr_data),
      .imask         (imask),
      .gie           (gie),
      .irptl         (irptl),
      .in_service    (in_service),
      .irq_req       (irq_req),
      .irq_vec       (irq_vec),
      .irq_wake      (irq_wake)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
   endtask

   function automatic logic [3:0] pack(input bit v [NUM]);
      logic [3:0] r;
      for (int i = 0; i < NUM; i++) r[i] = v[i];
      return r;
   endfunction

   function automatic int first_set(input bit v [NUM]);
      for (int i = 0; i < NUM; i++) if (v[i]) return i;
      return NUM;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NUM; i++) begin
         m_pend[i] = 0; m_mask[i] = 0; m_svc[i] = 0; m_prev[i] = 0;
      end
      m_gie = 0; m_busy = 0; m_wake = 0; m_idx = 0; m_vec = 0;
   endtask

   // One clock of the controller's rules, applied to the inputs seen at the edge.
   task automatic model_step();
      int  top_svc, cand;
      bit  found, go, ack;
      top_svc = first_set(m_svc);
      cand = NUM; found = 0;
      for (int i = 0; i < NUM; i++)
         if (!found && m_pend[i] && m_mask[i]) begin cand = i; found = 1; end
      go  = !m_busy && m_gie && found && (cand < top_svc);
      ack = m_busy && ps_irq_ack;
      if (ps_rti && top_svc < NUM) m_svc[top_svc] = 0;
      m_wake = 0;
      if (ack) begin
         m_pend[m_idx] = 0;
         m_svc[m_idx]  = 1;
         m_busy        = 0;
      end else if (go) begin
         m_busy = 1;
         m_idx  = cand;
         m_vec  = (VB + cand * VS) % 65536;
         m_wake = ps_idle;
      end
      for (int i = 0; i < NUM; i++) begin
         if (irq_in[i] && !m_prev[i]) m_pend[i] = 1;
         m_prev[i] = irq_in[i];
      end
      if (imask_wr_en) begin
         for (int i = 0; i < NUM; i++) m_mask[i] = imask_wr_data[i];
         m_gie = imask_wr_data[NUM];
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      if (reset) model_reset();
      else model_step();
      #1;
      check("irptl", irptl, pack(m_pend));
      check("in_service", in_service, pack(m_svc));
      check("imask", imask, pack(m_mask));
      check("gie", gie, m_gie);
      check("irq_req", irq_req, m_busy);
      check("irq_vec", irq_vec, m_vec);
      check("irq_wake", irq_wake, m_wake);
      if (irq_req && !last_req) rises++;
      if (irq_wake) wakes++;
      last_req = irq_req;
   endtask

   task automatic write_mask(input logic [4:0] d);
      imask_wr_en = 1'b1; imask_wr_data = d;
      cycle();
      imask_wr_en = 1'b0;
   endtask

   task automatic pulse_ack();
      ps_irq_ack = 1'b1; cycle(); ps_irq_ack = 1'b0;
   endtask

   task automatic pulse_rti();
      ps_rti = 1'b1; cycle(); ps_rti = 1'b0;
   endtask

   task automatic pulse_irq(input logic [3:0] v);
      irq_in = v; cycle(); irq_in = '0;
   endtask

   task automatic wait_req(input string tag, input int budget);
      int n = 0;
      while (!irq_req && n < budget) begin cycle(); n++; end
      check(tag, irq_req, 1'b1);
   endtask

   task automatic do_reset(input logic idle);
      reset = 1'b1; ps_idle = idle;
      irq_in = '0; ps_irq_ack = 1'b0; ps_rti = 1'b0; imask_wr_en = 1'b0;
      cycle(); cycle();
      reset = 1'b0;
   endtask

   task automatic rand_phase(input int ncyc, input logic idle, input logic gie_on);
      do_reset(idle);
      write_mask({gie_on, 4'hF});
      rises = 0; wakes = 0;
      for (int c = 0; c < ncyc; c++) begin
         irq_in     = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'h0;
         ps_irq_ack = irq_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
         ps_rti     = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 19) == 0) begin
            imask_wr_en   = 1'b1;
            imask_wr_data = {gie_on && ($urandom_range(0, 7) != 0), 4'($urandom)};
         end else begin
            imask_wr_en = 1'b0;
         end
         cycle();
      end
      irq_in = '0; ps_irq_ack = 1'b0; ps_rti = 1'b0; imask_wr_en = 1'b0;
      if (gie_on && idle) begin
         check("wake_per_req", wakes, rises);
         check("reqs_seen", rises != 0, 1'b1);
      end
      if (!gie_on) begin
         check("no_wake_gie0", wakes, 0);
         check("no_req_gie0", rises, 0);
      end
   endtask

   initial begin
      model_reset();
      last_req = 0; rises = 0; wakes = 0;
      cycle(); cycle();
      check("rst_irptl", irptl, 4'h0);
      check("rst_insvc", in_service, 4'h0);
      check("rst_req", irq_req, 1'b0);
      check("rst_vec", irq_vec, 16'h0);
      reset = 1'b0;

      // enable gate, vector and handshake
      write_mask(5'b1_0010);
      irq_in = 4'b0010; cycle();
      check("t1_irptl", irptl, 4'b0010);
      check("t1_noreq_yet", irq_req, 1'b0);
      cycle();
      check("t1_req", irq_req, 1'b1);
      check("t1_vec", irq_vec, 16'h0014);
      irq_in = '0; pulse_ack();
      check("t1_ack_irptl", irptl, 4'b0000);
      check("t1_ack_insvc", in_service, 4'b0010);
      check("t1_ack_req", irq_req, 1'b0);
      pulse_ack();
      check("t1_idle_ack", in_service, 4'b0010);
      pulse_rti();
      check("t1_rti", in_service, 4'b0000);
      pulse_rti();

      // masked request held until unmasked
      write_mask(5'b1_0000);
      pulse_irq(4'b0100);
      check("t2_irptl", irptl, 4'b0100);
      cycle(); cycle();
      check("t2_masked", irq_req, 1'b0);
      write_mask(5'b1_0100);
      check("t2_mask_next", irq_req, 1'b0);
      cycle();
      check("t2_req", irq_req, 1'b1);
      check("t2_vec", irq_vec, 16'h0018);
      pulse_ack();
      check("t2_insvc", in_service, 4'b0100);

      // preemption
      write_mask(5'b1_1111);
      pulse_irq(4'b1000); cycle(); cycle();
      check("t3_low_waits", irq_req, 1'b0);
      pulse_irq(4'b0001); cycle();
      check("t3_req0", irq_req, 1'b1);
      check("t3_vec0", irq_vec, 16'h0010);
      pulse_ack();
      check("t3_insvc", in_service, 4'b0101);
      pulse_rti();
      check("t3_rti1", in_service, 4'b0100);
      cycle();
      check("t3_still_wait", irq_req, 1'b0);
      pulse_rti();
      check("t3_rti2", in_service, 4'b0000);
      cycle();
      check("t3_req3", irq_req, 1'b1);
      check("t3_vec3", irq_vec, 16'h001C);
      pulse_ack(); pulse_rti();

      // new edge in the ack cycle of the same line
      pulse_irq(4'b0010);
      wait_req("s1_req", 5);
      irq_in = 4'b0010; ps_irq_ack = 1'b1; cycle();
      irq_in = '0; ps_irq_ack = 1'b0;
      check("s1_irptl", irptl, 4'b0010);
      check("s1_insvc", in_service, 4'b0010);
      cycle(); cycle();
      check("s1_equal_waits", irq_req, 1'b0);
      pulse_rti();
      wait_req("s1_rereq", 5);
      pulse_ack(); pulse_rti();

      // rti and ack together
      pulse_irq(4'b0100);
      wait_req("s2_req2", 5);
      pulse_ack();
      pulse_irq(4'b0001);
      wait_req("s2_req0", 5);
      ps_irq_ack = 1'b1; ps_rti = 1'b1; cycle();
      ps_irq_ack = 1'b0; ps_rti = 1'b0;
      check("s2_insvc", in_service, 4'b0001);
      pulse_rti();

      // asynchronous reset while a request is outstanding
      pulse_irq(4'b1000);
      wait_req("r_req", 5);
      #2 reset = 1'b1;
      #1;
      check("r_req_cleared", irq_req, 1'b0);
      check("r_vec_cleared", irq_vec, 16'h0);
      check("r_irptl", irptl, 4'h0);
      check("r_insvc", in_service, 4'h0);
      check("r_mask", {gie, imask}, 5'h0);
      check("r_wake", irq_wake, 1'b0);
      model_reset();
      cycle();
      reset = 1'b0;
      cycle();

      rand_phase(1500, 1'b1, 1'b1);
      rand_phase(1500, 1'b0, 1'b1);
      rand_phase(800, 1'b1, 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/irq_controller.md
Name: irq_controller

Overview:
- Latches external interrupt requests and masks them with a programmable mask register.
- Prioritises pending requests against those already in service and presents one vector at a time to the program sequencer through a req/ack handshake.
- Drives the wake signal that releases the sequencer from IDLE.
- Sits inside core_top between the core interrupt pins and the program sequencer (ps).

Parameters:
- NUM_IRQ, 4, number of interrupt lines; index 0 is highest priority.
- PMA_SIZE, 16, program memory address width; also the vector width.
- VEC_BASE, 16'h0010, vector address of irq 0.
- VEC_STRIDE, 4, address spacing between consecutive vectors.

Ports:
- clk  in  1  core clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- irq_in  in  NUM_IRQ  interrupt lines, synchronous to clk; rising edge is the event.
- ps_idle  in  1  sequencer is executing IDLE.
- ps_irq_ack  in  1  one-cycle pulse: sequencer has taken the current vector.
- ps_rti  in  1  one-cycle pulse: sequencer executed RTI.
- imask_wr_en  in  1  write strobe for mask and global enable.
- imask_wr_data  in  NUM_IRQ+1  bit NUM_IRQ is the global enable (gie); bits below are imask.
- imask  out  NUM_IRQ  current mask; 1 means enabled.
- gie  out  1  global interrupt enable.
- irptl  out  NUM_IRQ  latched pending bits.
- in_service  out  NUM_IRQ  interrupts currently being serviced (nesting state).
- irq_req  out  1  vector request to the sequencer.
- irq_vec  out  PMA_SIZE  vector address; valid while irq_req is high.
- irq_wake  out  1  wake pulse to the sequencer in IDLE.

Behaviour:
- Reset: imask=0, gie=0, irptl=0, in_service=0, irq_req=0, irq_vec=0, irq_wake=0, edge register=0, state=IDLE.
- Reset asserted mid-handshake discards the request and returns immediately to the reset values.
- Edge detect: one register holds the previous irq_in. Event = irq_in & ~prev. Each event sets its irptl bit in the same cycle, regardless of mask.
- A level held high produces one event only.
- eligible = irptl & imask. The candidate is the lowest index in eligible.
- A candidate qualifies only if gie=1 and its index is lower than every set in_service bit (strict preemption). Equal or lower priority waits.
- State machine:
  - IDLE: on a qualifying candidate, register irq_vec = VEC_BASE + idx*VEC_STRIDE (truncated to PMA_SIZE bits), store idx, set irq_req=1, go to REQ. Latency is one cycle from the irptl bit setting to irq_req=1, which makes it two clocks from the irq_in rising edge.
  - REQ: irq_req and irq_vec are held stable. Mask writes and new higher-priority events do not retarget a committed request. On ps_irq_ack: clear irptl[idx], set in_service[idx], drop irq_req in the next cycle, go to IDLE. The next request can be issued no earlier than one cycle after that IDLE cycle.
- ps_irq_ack in IDLE is ignored.
- ps_rti clears the lowest-index set in_service bit. With in_service=0, ps_rti is a no-op.
- Simultaneous events:
  - A new event on bit idx in the same cycle as the ack that clears it: the set wins, and irptl[idx] stays 1.
  - ps_rti in the same cycle as ps_irq_ack: the rti clears the lowest set in_service bit present before the ack, then the ack's bit is set.
  - imask_wr_en takes effect on the next cycle's qualification.
- irq_wake: one-cycle pulse, asserted in the cycle irq_req rises while ps_idle=1.
- A masked pending bit stays latched and is serviced once it is unmasked.

Decomposition:
- Shared package (core_pkg): state enum {IDLE, REQ}; constants VEC_BASE and VEC_STRIDE; NUM_IRQ default.
- One natural sub-module: irq_prio_enc. It is a combinational lowest-index priority encoder with a valid output, reused for candidate selection and for the RTI clear.

Test Plan:
- Mask and enable gate, vector, handshake: after reset, write imask_wr_data=5'b1_0010, then pulse irq_in[1] -> irptl=4'b0010 next cycle; irq_req=1 with irq_vec=16'h0014 one cycle later; ack -> irptl=0, in_service=4'b0010, irq_req=0.
- Masked request: gie=1, imask=0, pulse irq_in[2] -> irptl=4'b0100 and no irq_req; then write imask=4'b0100 -> irq_req with irq_vec=16'h0018.
- Preemption: in_service=4'b0100; pulse irq_in[3] -> no request. Pulse irq_in[0] -> request with 16'h0010; ack -> in_service=4'b0101. Two ps_rti pulses clear bit0 and then bit2, after which the pending irq3 is requested with 16'h001C.
- Idle wake, modelled on the core bench: ps_idle=1 with random irq_in pulses -> each request rises with exactly one irq_wake pulse. With gie=0, irq_wake is never asserted.
- Simultaneous events:
  - irq_in[1] rising edge in the ack cycle for irq1 -> irptl[1] remains 1.
  - rti and ack in the same cycle -> in_service has the old bit cleared and the new bit set.
- Reset during REQ: assert reset asynchronously -> irq_req=0, irq_vec=0 and all registers at 0 before the next clk edge.
